// File: rtl/des_pkg.sv
// des_pkg: shared DES constants and helpers for the iterative core.
//   - FSM state type, permutation tables (IP, FP, E, P, PC1, PC2), S-boxes,
//     per-round key shift schedule.
//   - Functions ip, fp, pc1, pc2, feistel_f, rotl28, rotr28.
// Table entries use DES bit numbering (bit 1 = MSB of the vector).
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} des_state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Row-major: entry index = row * 16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Left-rotate amount for encrypt rounds 1..16 (entry 0 = round 1).
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  // Parity bits (8, 16, ..., 64) are simply never selected.
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    x = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = x[6'(42 - 6 * j) +: 6];
      // row = outer bits, column = inner four bits
      s[5'(28 - 4 * j) +: 4] = 4'(SBOX[3'(j)][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_ks_round.sv
// des_ks_round: one combinational Feistel round with its key-schedule step.
//   l, r            : current halves
//   c, d            : current key-schedule registers
//   round_idx       : DES round number 1..16
//   decrypt         : 0 = rotate-then-use (K1..K16), 1 = use-then-rotate-back (K16..K1)
//   l_next..d_next  : state after this round
module des_ks_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic [4:0]  round_idx,
  input  logic        decrypt,
  output logic [31:0] l_next,
  output logic [31:0] r_next,
  output logic [27:0] c_next,
  output logic [27:0] d_next
);

  logic [1:0]  enc_shift;
  logic [1:0]  dec_shift;
  logic [27:0] c_enc;
  logic [27:0] d_enc;
  logic [47:0] k;

  assign enc_shift = SHIFTS[4'(round_idx - 5'd1)];
  // Decrypt undoes the shift of the round that follows; nothing after round 16.
  assign dec_shift = (round_idx >= 5'd16) ? 2'd0 : SHIFTS[4'(round_idx)];

  assign c_enc = rotl28(c, enc_shift);
  assign d_enc = rotl28(d, enc_shift);

  assign k      = decrypt ? pc2({c, d}) : pc2({c_enc, d_enc});
  assign c_next = decrypt ? rotr28(c, dec_shift) : c_enc;
  assign d_next = decrypt ? rotr28(d, dec_shift) : d_enc;

  assign l_next = r;
  assign r_next = l ^ feistel_f(r, k);

endmodule

// File: rtl/des_iter_core.sv
// des_iter_core: iterative single-DES engine, ROUNDS_PER_CYCLE rounds per clock.
//   clk, nrst            : clock, async active-low reset
//   clear                : synchronous abort back to IDLE
//   in_valid/in_ready    : input handshake for in_data, in_key, in_decrypt
//   out_valid/out_ready  : output handshake, out_data registered and held
//   busy                 : high while iterating
//
// state | meaning
// IDLE  | waiting for a block
// RUN   | iterating the rounds
// DONE  | holding the result until out_ready
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int N_ITER = 16 / ROUNDS_PER_CYCLE;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16) ||
      (N_ITER * ROUNDS_PER_CYCLE != 16)) begin : g_bad_rounds
    $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  des_state_t  state;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [4:0]  round_cnt;
  logic        mode_q;
  logic        accept;
  logic        last;

  logic [31:0] l_c [ROUNDS_PER_CYCLE + 1];
  logic [31:0] r_c [ROUNDS_PER_CYCLE + 1];
  logic [27:0] c_c [ROUNDS_PER_CYCLE + 1];
  logic [27:0] d_c [ROUNDS_PER_CYCLE + 1];

  assign l_c[0] = l_q;
  assign r_c[0] = r_q;
  assign c_c[0] = c_q;
  assign d_c[0] = d_q;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
    des_ks_round u_round (
      .l         (l_c[g]),
      .r         (r_c[g]),
      .c         (c_c[g]),
      .d         (d_c[g]),
      .round_idx (round_cnt + 5'(g + 1)),
      .decrypt   (mode_q),
      .l_next    (l_c[g + 1]),
      .r_next    (r_c[g + 1]),
      .c_next    (c_c[g + 1]),
      .d_next    (d_c[g + 1])
    );
  end

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign last     = ((round_cnt + 5'(ROUNDS_PER_CYCLE)) == 5'd16);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      l_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      round_cnt <= '0;
      mode_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Covers both IDLE and the back-to-back hand-off from DONE.
      {l_q, r_q} <= ip(in_data);
      {c_q, d_q} <= pc1(in_key);
      mode_q     <= in_decrypt;
      round_cnt  <= '0;
      state      <= RUN;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          l_q       <= l_c[ROUNDS_PER_CYCLE];
          r_q       <= r_c[ROUNDS_PER_CYCLE];
          c_q       <= c_c[ROUNDS_PER_CYCLE];
          d_q       <= d_c[ROUNDS_PER_CYCLE];
          round_cnt <= round_cnt + 5'(ROUNDS_PER_CYCLE);
          if (last) begin
            out_data  <= fp({r_c[ROUNDS_PER_CYCLE], l_c[ROUNDS_PER_CYCLE]});
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_iter_core.sv
module tb_des_iter_core;

  localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] D87  = 64'h8787878787878787;
  localparam logic [63:0] Z64  = 64'h0000000000000000;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int r, input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s (R=%0d): got %h, expected %h", name, r, act, exp_v);
    end
  endtask

  task automatic check1(input int r, input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s (R=%0d): got %b, expected %b", name, r, act, exp_v);
    end
  endtask

  task automatic fail(input int r, input string name);
    checks++;
    errors++;
    $display("FAIL %s (R=%0d): event did not occur within bound", name, r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 5; gi++) begin : g_inst
    localparam int R = 1 << gi;
    localparam int N = 16 / R;

    logic        nrst, clear, in_valid, in_ready, in_decrypt;
    logic        out_valid, out_ready, busy;
    logic [63:0] in_data, in_key, out_data;
    logic [63:0] exp_q [$];
    int          acc_q [$];
    bit          done = 1'b0;

    des_iter_core #(.ROUNDS_PER_CYCLE(R)) u_dut (
      .clk        (clk),
      .nrst       (nrst),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_key     (in_key),
      .in_decrypt (in_decrypt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
    );

    // Monitor: latency on out_valid rise, data on output handshake.
    initial begin
      logic prev_ov;
      int   a_cyc;
      prev_ov = 1'b0;
      forever begin
        @(negedge clk);
        if (nrst) begin
          if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) fail(R, "latency_no_accept");
            else begin
              a_cyc = acc_q.pop_front();
              check(R, "latency", 64'(cyc - a_cyc), 64'(N));
            end
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail(R, "unexpected_output");
            else check(R, "out_data", out_data, exp_q.pop_front());
          end
          if (in_valid && in_ready && !clear) acc_q.push_back(cyc + 1);
        end
        prev_ov = out_valid;
      end
    end

    // Call at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic drive(input logic [63:0] key, input logic [63:0] data, input logic dec,
                         input logic [63:0] exp_v, output int acc_cyc);
      int t;
      in_key = key;
      in_data = data;
      in_decrypt = dec;
      in_valid = 1'b1;
      t = 0;
      acc_cyc = -1;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) fail(R, "accept_timeout");
      else begin
        exp_q.push_back(exp_v);
        acc_cyc = cyc + 1;
      end
      tick();
      in_valid = 1'b0;
    endtask

    task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        tick();
        t++;
      end
      if (exp_q.size() != 0) fail(R, "drain_timeout");
    endtask

    task automatic wait_out_valid();
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid) fail(R, "out_valid_timeout");
    endtask

    initial begin
      int a0, a1, a2;
      nrst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
      out_ready = 1'b1; in_data = '0; in_key = '0;

      @(negedge clk);
      check1(R, "rst_in_ready", in_ready, 1'b1);
      check1(R, "rst_out_valid", out_valid, 1'b0);
      check1(R, "rst_busy", busy, 1'b0);
      check(R, "rst_out_data", out_data, Z64);
      tick();
      tick();
      nrst = 1'b1;
      tick();

      // Encrypt / decrypt round trip
      drive(KEY1, PT1, 1'b0, CT1, a0);
      drain();
      drive(KEY1, CT1, 1'b1, PT1, a0);
      drain();

      // Backpressure: result held, extra in_valid ignored
      out_ready = 1'b0;
      drive(KEY2, D87, 1'b0, Z64, a0);
      wait_out_valid();
      in_key = KEY1; in_data = PT1; in_decrypt = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check1(R, "hold_in_ready", in_ready, 1'b0);
        check1(R, "hold_out_valid", out_valid, 1'b1);
        check(R, "hold_out_data", out_data, Z64);
      end
      tick();
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();

      // Back-to-back with alternating mode
      drive(KEY1, PT1, 1'b0, CT1, a0);
      drive(KEY1, CT1, 1'b1, PT1, a1);
      drive(KEY2, D87, 1'b0, Z64, a2);
      check(R, "b2b_spacing_1", 64'(a1 - a0), 64'(N + 1));
      check(R, "b2b_spacing_2", 64'(a2 - a1), 64'(N + 1));
      drain();

      // Clear mid-run (round_cnt = 7 at R=1)
      drive(KEY1, PT1, 1'b0, CT1, a0);
      repeat (7 / R) tick();
      check1(R, "busy_before_clear", busy, 1'b1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check1(R, "clear_busy", busy, 1'b0);
      check1(R, "clear_in_ready", in_ready, 1'b1);
      exp_q.delete();
      acc_q.delete();
      repeat (N + 2) tick();
      check1(R, "clear_out_valid", out_valid, 1'b0);
      // clear wins over a simultaneous in_valid
      in_key = KEY1; in_data = PT1; in_decrypt = 1'b0;
      in_valid = 1'b1;
      clear = 1'b1;
      tick();
      in_valid = 1'b0;
      clear = 1'b0;
      check1(R, "clear_blocks_accept", busy, 1'b0);
      drive(KEY2, Z64, 1'b1, D87, a0);
      drain();

      // Reset mid-RUN
      drive(KEY1, PT1, 1'b0, CT1, a0);
      check1(R, "busy_before_rst", busy, 1'b1);
      #2;
      nrst = 1'b0;
      #1;
      check1(R, "rst_run_busy", busy, 1'b0);
      check1(R, "rst_run_out_valid", out_valid, 1'b0);
      check1(R, "rst_run_in_ready", in_ready, 1'b1);
      check(R, "rst_run_out_data", out_data, Z64);
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      nrst = 1'b1;
      tick();
      check1(R, "post_rst_in_ready", in_ready, 1'b1);

      // Reset while holding a result
      out_ready = 1'b0;
      drive(KEY1, CT1, 1'b1, PT1, a0);
      wait_out_valid();
      check(R, "done_out_data", out_data, PT1);
      #2;
      nrst = 1'b0;
      #1;
      check1(R, "rst_done_out_valid", out_valid, 1'b0);
      check1(R, "rst_done_in_ready", in_ready, 1'b1);
      check(R, "rst_done_out_data", out_data, Z64);
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      nrst = 1'b1;
      tick();
      out_ready = 1'b1;

      drive(KEY2, D87, 1'b0, Z64, a0);
      drain();
      drive(KEY1, PT1, 1'b0, CT1, a0);
      drain();
      tick();
      done = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done &&
             g_inst[3].done && g_inst[4].done) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 20000) fail(0, "global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
